// File: rtl/sys_block_param.sv
// System/ID register block on Wishbone: ID constants, scratchpads,
// synchronised status inputs, control outputs, uptime and error counters.
module sys_block_param #(
  parameter logic [31:0] BOARD_ID    = 32'h0,
  parameter logic [31:0] REV_MAJ     = 32'h0,
  parameter logic [31:0] REV_MIN     = 32'h0,
  parameter logic [31:0] REV_RCS     = 32'h0,
  parameter int          N_SCRATCH   = 4,
  parameter int          N_IN        = 8,
  parameter int          N_OUT       = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] REGOUT_RST  = 32'h0
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  input  logic [32*N_IN-1:0]    regin,
  output logic [32*N_OUT-1:0]   regout,
  output logic [N_OUT-1:0]      regout_we
);

  logic [5:0]  w;
  logic [31:0] wi;
  logic        unused_adr;
  logic        req;
  logic        hit;
  logic [31:0] rdata;

  logic [31:0]         scratch [N_SCRATCH];
  logic [63:0]         up_q;
  logic [31:0]         up_hi_q;
  logic [31:0]         err_cnt_q;
  logic [32*N_IN-1:0]  sync_q [SYNC_STAGES];
  logic [32*N_IN-1:0]  regin_s;
  logic [32*N_OUT-1:0] regout_q;

  assign w          = wb_adr_i[7:2];
  assign wi         = {26'd0, w};
  assign unused_adr = ^{wb_adr_i[31:8], wb_adr_i[1:0]};
  assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign regin_s    = sync_q[SYNC_STAGES-1];
  assign regout     = regout_q;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always_comb begin
    hit   = 1'b0;
    rdata = '0;
    if (wi <= 32'd6) begin
      hit = 1'b1;
      case (w)
        6'd0:    rdata = BOARD_ID;
        6'd1:    rdata = REV_MAJ;
        6'd2:    rdata = REV_MIN;
        6'd3:    rdata = REV_RCS;
        6'd4:    rdata = up_q[31:0];
        6'd5:    rdata = up_hi_q;
        6'd6:    rdata = err_cnt_q;
        default: rdata = '0;
      endcase
    end
    for (int k = 0; k < N_SCRATCH; k++)
      if (wi == 32'(8 + k)) begin
        hit   = 1'b1;
        rdata = scratch[k];
      end
    for (int k = 0; k < N_IN; k++)
      if (wi == 32'(16 + k)) begin
        hit   = 1'b1;
        rdata = regin_s[32*k +: 32];
      end
    for (int k = 0; k < N_OUT; k++)
      if (wi == 32'(32 + k)) begin
        hit   = 1'b1;
        rdata = regout_q[32*k +: 32];
      end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req & hit;
      wb_err_o <= req & ~hit;
      if (req && !hit)
        wb_dat_o <= '0;
      else if (req && !wb_we_i)
        wb_dat_o <= rdata;
    end
  end

  // HI shadow is captured with the LO read so a 64-bit read is atomic
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      up_q    <= '0;
      up_hi_q <= '0;
    end else begin
      if (req && wb_we_i && w == 6'd4)
        up_q <= '0;
      else
        up_q <= up_q + 64'd1;
      if (req && !wb_we_i && w == 6'd4)
        up_hi_q <= up_q[63:32];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      err_cnt_q <= '0;
    else if (req && !hit) begin
      if (err_cnt_q != '1)
        err_cnt_q <= err_cnt_q + 32'd1;
    end else if (req && wb_we_i && w == 6'd6)
      err_cnt_q <= '0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int k = 0; k < N_SCRATCH; k++)
        scratch[k] <= '0;
    end else if (req && wb_we_i) begin
      for (int k = 0; k < N_SCRATCH; k++)
        if (wi == 32'(8 + k))
          scratch[k] <= merge(scratch[k], wb_dat_i, wb_sel_i);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      regout_q  <= {N_OUT{REGOUT_RST}};
      regout_we <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        regout_we[k] <= 1'b0;
        if (req && wb_we_i && wi == 32'(32 + k)) begin
          regout_we[k]       <= 1'b1;
          regout_q[32*k +: 32] <=
            merge(regout_q[32*k +: 32], wb_dat_i, wb_sel_i);
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_q[s] <= '0;
    end else begin
      sync_q[0] <= regin;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
    end
  end

endmodule

// File: tb/tb_sys_block_param.sv
// Directed bench for sys_block_param: vector table plus
// sequences for held strobe, regout pulses, sync, uptime, reset.
module tb_sys_block_param;

  localparam logic [31:0] RRST = 32'hC0DE0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dati = '0;
  logic [31:0] dato;
  logic        ack, err;
  logic [255:0] regin;
  logic [255:0] regout;
  logic [7:0]  regout_we;

  int pass_cnt = 0;
  int total    = 0;
  int tbc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tbc <= tbc + 1;

  sys_block_param #(
    .BOARD_ID(32'hB0A2D000), .REV_MAJ(32'h1), .REV_MIN(32'h2),
    .REV_RCS(32'h3), .N_SCRATCH(4), .N_IN(8), .N_OUT(8),
    .SYNC_STAGES(2), .REGOUT_RST(RRST)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_we_i(we), .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dati),
    .wb_dat_o(dato), .wb_ack_o(ack), .wb_err_o(err),
    .regin(regin), .regout(regout), .regout_we(regout_we)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic xfer(input logic wr, input logic [5:0] wd,
                      input logic [3:0] s, input logic [31:0] d,
                      output logic a, output logic e,
                      output logic [31:0] q);
    @(negedge clk);
    cyc = 1; stb = 1; we = wr; adr = {24'd0, wd, 2'b00};
    sel = s; dati = d;
    @(posedge clk); #1;
    a = ack; e = err; q = dato;
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
  endtask

  typedef struct {
    logic        wr;
    logic [5:0]  wd;
    logic [3:0]  s;
    logic [31:0] d;
    logic        ea;
    logic        ee;
    logic        cd;
    logic [31:0] ed;
  } vec_t;

  vec_t vt [27];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic a, e;
    logic [31:0] q, lo1, lo2;
    int c1, c2;
    logic [1:0] ab [4];

    for (int k = 0; k < 8; k++)
      regin[32*k +: 32] = 32'h11111111 * (k + 1);

    vt[0]  = '{0, 0,  4'hF, 0, 1, 0, 1, 32'hB0A2D000};
    vt[1]  = '{0, 1,  4'hF, 0, 1, 0, 1, 32'h1};
    vt[2]  = '{0, 2,  4'hF, 0, 1, 0, 1, 32'h2};
    vt[3]  = '{0, 3,  4'hF, 0, 1, 0, 1, 32'h3};
    vt[4]  = '{1, 8,  4'h5, 32'h12345678, 1, 0, 0, 0};
    vt[5]  = '{0, 8,  4'hF, 0, 1, 0, 1, 32'h00340078};
    vt[6]  = '{1, 8,  4'h0, 32'hFFFFFFFF, 1, 0, 0, 0};
    vt[7]  = '{0, 8,  4'hF, 0, 1, 0, 1, 32'h00340078};
    vt[8]  = '{1, 0,  4'hF, 32'hFFFFFFFF, 1, 0, 0, 0};
    vt[9]  = '{0, 0,  4'hF, 0, 1, 0, 1, 32'hB0A2D000};
    vt[10] = '{0, 32, 4'hF, 0, 1, 0, 1, RRST};
    vt[11] = '{0, 39, 4'hF, 0, 1, 0, 1, RRST};
    vt[12] = '{0, 40, 4'hF, 0, 0, 1, 1, 32'h0};
    vt[13] = '{0, 7,  4'hF, 0, 0, 1, 1, 32'h0};
    vt[14] = '{1, 60, 4'hF, 32'h5, 0, 1, 1, 32'h0};
    vt[15] = '{0, 6,  4'hF, 0, 1, 0, 1, 32'h3};
    vt[16] = '{1, 6,  4'hF, 32'h77, 1, 0, 0, 0};
    vt[17] = '{0, 6,  4'hF, 0, 1, 0, 1, 32'h0};
    vt[18] = '{0, 12, 4'hF, 0, 0, 1, 1, 32'h0};
    vt[19] = '{0, 24, 4'hF, 0, 0, 1, 1, 32'h0};
    vt[20] = '{0, 6,  4'hF, 0, 1, 0, 1, 32'h2};
    vt[21] = '{1, 17, 4'hF, 32'h0, 1, 0, 0, 0};
    vt[22] = '{0, 17, 4'hF, 0, 1, 0, 1, 32'h22222222};
    vt[23] = '{0, 11, 4'hF, 0, 1, 0, 1, 32'h0};
    vt[24] = '{0, 23, 4'hF, 0, 1, 0, 1, 32'h88888888};
    vt[25] = '{1, 5,  4'hF, 32'h9, 1, 0, 0, 0};
    vt[26] = '{0, 5,  4'hF, 0, 1, 0, 1, 32'h0};

    #23;
    chk("rst_ack", {31'd0, ack}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_dat", dato, 0);
    chk("rst_we", {24'd0, regout_we}, 0);
    for (int k = 0; k < 8; k++)
      chk("rst_regout", regout[32*k +: 32], RRST);
    @(negedge clk); rst = 0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 27; i++) begin
      xfer(vt[i].wr, vt[i].wd, vt[i].s, vt[i].d, a, e, q);
      chk($sformatf("vec%0d_ackerr", i), {30'd0, a, e},
          {30'd0, vt[i].ea, vt[i].ee});
      if (vt[i].cd) chk($sformatf("vec%0d_dat", i), q, vt[i].ed);
    end

    // held strobe: acks on alternate cycles only
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 32'h20; sel = 4'h5;
    dati = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ab[i] = {ack, err};
    end
    @(negedge clk); cyc = 0; stb = 0; we = 0;
    chk("held0", {30'd0, ab[0]}, 2);
    chk("held1", {30'd0, ab[1]}, 0);
    chk("held2", {30'd0, ab[2]}, 2);
    chk("held3", {30'd0, ab[3]}, 0);

    // regout write and one-cycle strobe
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 33 << 2; sel = 4'hF;
    dati = 32'hDEADBEEF;
    @(posedge clk); #1;
    chk("w33_ack", {31'd0, ack}, 1);
    chk("w33_we", {24'd0, regout_we}, 32'h2);
    chk("w33_val", regout[63:32], 32'hDEADBEEF);
    chk("w33_w0", regout[31:0], RRST);
    chk("w33_w2", regout[95:64], RRST);
    @(negedge clk); cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    chk("w33_we_off", {24'd0, regout_we}, 0);
    xfer(0, 33, 4'hF, 0, a, e, q);
    chk("r33", q, 32'hDEADBEEF);

    // regin synchroniser delay
    @(negedge clk);
    regin[127:96] = 32'hA5A5A5A5;
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 19 << 2;
    @(posedge clk); #1;
    chk("sync_old_ack", {31'd0, ack}, 1);
    chk("sync_old", dato, 32'h44444444);
    @(posedge clk); #1;
    chk("sync_gap", {31'd0, ack}, 0);
    @(posedge clk); #1;
    chk("sync_new_ack", {31'd0, ack}, 1);
    chk("sync_new", dato, 32'hA5A5A5A5);
    @(negedge clk); cyc = 0; stb = 0;

    // uptime tracks cycles, HI comes from shadow, write clears
    xfer(0, 4, 4'hF, 0, a, e, lo1); c1 = tbc;
    xfer(0, 4, 4'hF, 0, a, e, lo2); c2 = tbc;
    chk("up_delta", lo2 - lo1, 32'(c2 - c1));
    xfer(0, 5, 4'hF, 0, a, e, q);
    chk("up_hi", q, 0);
    xfer(1, 4, 4'h0, 32'h0, a, e, q);
    chk("up_clr_ack", {31'd0, a}, 1);
    xfer(0, 4, 4'hF, 0, a, e, q);
    chk("up_clr", {31'd0, q < 32'd4}, 1);

    // reset while acking drops ack and strobe at once
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 34 << 2; sel = 4'hF;
    dati = 32'h0BADF00D;
    @(posedge clk); #1;
    chk("rmid_ack", {31'd0, ack}, 1);
    rst = 1; #1;
    chk("rmid_ack0", {31'd0, ack}, 0);
    chk("rmid_we0", {24'd0, regout_we}, 0);
    chk("rmid_val", regout[95:64], RRST);
    @(negedge clk);
    adr = 35 << 2;
    @(posedge clk); #1;
    chk("rhold_ack", {30'd0, ack, err}, 0);
    @(negedge clk); rst = 0; cyc = 0; stb = 0; we = 0;
    xfer(0, 35, 4'hF, 0, a, e, q);
    chk("rhold_val", q, RRST);
    xfer(0, 6, 4'hF, 0, a, e, q);
    chk("rst_errcnt", q, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
